mem_sequencer: RTL and testbench

- Multi-cycle controller that sequences the 16-bit single-cycle datapath over one shared, variable-latency memory port.
- Fetches each instruction, performs the optional data access, then pulses the datapath enable for exactly one commit cycle.
- Arbitrates the same memory port between the CPU and one external requester (loader/debug), with a ready-timeout watchdog.

---
 rtl/mem_sequencer_pkg.sv | 18 +
 rtl/mem_sequencer_watchdog.sv | 30 +++
 rtl/mem_sequencer.sv | 172 +++++++++++++++++
 tb/tb_mem_sequencer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sequencer_pkg.sv
// Shared definitions for the memory sequencer: FSM state encoding and
// the default memory-ready watchdog limit.
package mem_sequencer_pkg;

    localparam int TIMEOUT_DEFAULT = 15;
    localparam int WD_W            = 8;

    typedef enum logic [2:0] {
        ST_ARB    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_DATA   = 3'd3,
        ST_COMMIT = 3'd4,
        ST_EXT    = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

endpackage

// File: rtl/mem_sequencer_watchdog.sv
// Counts cycles an access waits for mem_ready; expired fires on the wait
// cycle that brings the count up to TIMEOUT.
module mem_watchdog
    import mem_sequencer_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic active,
    input  logic ready,
    output logic expired
);

    logic [WD_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (active && !ready) begin
            count <= count + WD_W'(1);
        end
    end

    assign expired = active && !ready && (count == WD_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_sequencer.sv
// Multi-cycle sequencer for the single-cycle datapath: fetch, optional data
// access and commit over one shared memory port, arbitrated with an external requester.
module mem_sequencer
    import mem_sequencer_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic [DATA_W-1:0] instr,
    input  logic              cpu_mem_r,
    input  logic              cpu_mem_w,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_enable,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_grant,
    output logic              ext_done,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              bus_error
);

    // state     | meaning
    // ST_ARB    | idle, choose between CPU and external requester
    // ST_FETCH  | instruction read at pc_addr
    // ST_DECODE | settle cycle, datapath decodes instr
    // ST_DATA   | load/store at cpu_addr
    // ST_COMMIT | cpu_enable strobe
    // ST_EXT    | external access, ext_grant high
    // ST_ERROR  | ready timeout, dead until reset

    state_t state;
    logic   ext_last;
    logic   wd_expired;
    logic   grant_ext;

    // ext_last makes the requester yield one turn to the CPU unless halted
    assign grant_ext = ext_req && (!ext_last || halt);

    mem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (!mem_req),
        .active  (mem_req),
        .ready   (mem_ready),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_ARB;
            ext_last   <= 1'b0;
            instr      <= '0;
            cpu_rdata  <= '0;
            cpu_enable <= 1'b0;
            ext_grant  <= 1'b0;
            ext_done   <= 1'b0;
            ext_rdata  <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            bus_error  <= 1'b0;
        end else begin
            cpu_enable <= 1'b0;
            ext_done   <= 1'b0;
            case (state)
                ST_ARB: begin
                    if (grant_ext) begin
                        state     <= ST_EXT;
                        ext_grant <= 1'b1;
                        mem_req   <= 1'b1;
                        mem_we    <= ext_we;
                        mem_addr  <= ext_addr;
                        mem_wdata <= ext_wdata;
                    end else if (!halt) begin
                        state    <= ST_FETCH;
                        ext_last <= 1'b0;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc_addr;
                    end
                end
                ST_FETCH: begin
                    if (mem_ready) begin
                        instr   <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= ST_DECODE;
                    end else if (wd_expired) begin
                        bus_error <= 1'b1;
                        mem_req   <= 1'b0;
                        state     <= ST_ERROR;
                    end
                end
                ST_DECODE: begin
                    if (cpu_mem_w || cpu_mem_r) begin
                        state     <= ST_DATA;
                        mem_req   <= 1'b1;
                        mem_we    <= cpu_mem_w;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                    end else begin
                        state      <= ST_COMMIT;
                        cpu_enable <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (mem_ready) begin
                        if (!mem_we) begin
                            cpu_rdata <= mem_rdata;
                        end
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        cpu_enable <= 1'b1;
                        state      <= ST_COMMIT;
                    end else if (wd_expired) begin
                        bus_error <= 1'b1;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        state     <= ST_ERROR;
                    end
                end
                ST_COMMIT: begin
                    state <= ST_ARB;
                end
                ST_EXT: begin
                    if (mem_ready) begin
                        if (!mem_we) begin
                            ext_rdata <= mem_rdata;
                        end
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        ext_grant <= 1'b0;
                        ext_done  <= 1'b1;
                        ext_last  <= 1'b1;
                        state     <= ST_ARB;
                    end else if (wd_expired) begin
                        bus_error <= 1'b1;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        ext_grant <= 1'b0;
                        state     <= ST_ERROR;
                    end
                end
                ST_ERROR: begin
                    mem_req   <= 1'b0;
                    ext_grant <= 1'b0;
                end
                default: begin
                    state <= ST_ARB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_sequencer.sv
// Bench for mem_sequencer: random requester, halt and memory wait states
// checked every cycle against a transaction-level model of the sequencer.
module tb_mem_sequencer;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        halt = 1'b0;
    logic [15:0] pc_addr;
    logic [15:0] instr;
    logic        cpu_mem_r, cpu_mem_w;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_enable;
    logic        ext_req = 1'b0, ext_we = 1'b0;
    logic [15:0] ext_addr = '0, ext_wdata = '0;
    logic        ext_grant, ext_done;
    logic [15:0] ext_rdata;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        bus_error;

    // stimulus controls written only by the main process
    int          halt_sel = 0;     // 0 low, 1 high, 2 random
    int          ext_mode = 0;     // 0 off, 1 random, 2 held high at 0x0100
    int          maxw = 0;
    logic [15:0] slow_addr = 16'h0040;
    int          slow_n = 2;
    bit          stuck = 0;
    bit          pc_rand = 0;
    bit          rf_rand = 0;
    logic [15:0] rf_fixed = 16'h00AA;
    logic [15:0] pc_base = '0;
    logic [15:0] dmem [logic [15:0]];

    logic [15:0] pc_ofs = '0;
    logic [15:0] rf_q = '0;

    int n_cmp = 0;
    int n_fail = 0;

    // model state
    logic        m_last, m_done_pend, m_err;
    logic [15:0] e_instr, e_cpu_rd, e_ext_rd, m_fetch_addr;
    int          n_fetch = 0, n_ext = 0, last_kind, last_len;

    assign pc_addr   = pc_base + pc_ofs;
    assign cpu_mem_r = instr[15];
    assign cpu_mem_w = instr[14];
    assign cpu_addr  = {4'h0, instr[11:0]};
    assign cpu_wdata = rf_rand ? rf_q : rf_fixed;

    mem_sequencer #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .halt(halt), .pc_addr(pc_addr), .instr(instr),
        .cpu_mem_r(cpu_mem_r), .cpu_mem_w(cpu_mem_w), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_enable(cpu_enable),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_grant(ext_grant), .ext_done(ext_done), .ext_rdata(ext_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_error(bus_error)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // datapath stand-in: PC and store data advance on each commit
    initial begin : pc_drv
        logic en;
        forever begin
            @(negedge clk);
            en = cpu_enable;
            @(posedge clk);
            #1;
            if (reset) pc_ofs = '0;
            else if (en) begin
                pc_ofs = pc_ofs + (pc_rand ? 16'($urandom_range(1, 5)) : 16'd1);
                rf_q   = 16'($urandom);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (halt_sel)
            0: halt = 1'b0;
            1: halt = 1'b1;
            default: halt = ($urandom_range(0, 4) == 0);
        endcase
    end

    initial forever begin : requester
        @(posedge clk);
        #1;
        if (reset) ext_req = 1'b0;
        else if (ext_done) begin
            if (ext_mode != 2) ext_req = 1'b0;
        end else if (!ext_req && ext_mode != 0 && (ext_mode == 2 || $urandom_range(0, 2) == 0)) begin
            ext_req   = 1'b1;
            ext_we    = (ext_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            ext_addr  = (ext_mode == 2) ? 16'h0100 : 16'($urandom);
            ext_wdata = 16'($urandom);
        end
    end

    initial begin : responder
        int wcnt, target;
        wcnt = 0;
        target = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!mem_req) begin
                mem_ready = 1'b0;
                wcnt      = 0;
                target    = (maxw == 0) ? 0 : $urandom_range(0, maxw);
                mem_rdata = 16'($urandom);
            end else begin
                if (wcnt == 0 && mem_addr == slow_addr) target = slow_n;
                if (!stuck && wcnt >= target) begin
                    mem_ready = 1'b1;
                    mem_rdata = dmem.exists(mem_addr) ? dmem[mem_addr] : 16'($urandom);
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = 16'($urandom);
                end
                wcnt++;
            end
        end
    end

    task automatic chk_regs();
        chk("instr", instr, e_instr);
        chk("cpu_rdata", cpu_rdata, e_cpu_rd);
        chk("ext_rdata", ext_rdata, e_ext_rd);
        chk("bus_error", bus_error, 0);
    endtask

    task automatic idle_cycle(input logic exp_en);
        @(negedge clk);
        last_len++;
        chk_regs();
        chk("idle_mem_req", mem_req, 0);
        chk("idle_ext_grant", ext_grant, 0);
        chk("idle_ext_done", ext_done, 0);
        chk("cpu_enable", cpu_enable, exp_en);
    endtask

    // one memory access: request held with fixed attributes until ready
    task automatic access(input logic grant, input logic we, input logic [15:0] addr,
                          input logic [15:0] wd, output logic [15:0] rd, output logic ok);
        int  waits;
        bit  fin;
        waits = 0;
        fin = 0;
        ok = 1'b0;
        rd = '0;
        while (!fin) begin
            @(negedge clk);
            last_len++;
            chk_regs();
            chk("mem_req", mem_req, 1);
            chk("mem_we", mem_we, we);
            chk("mem_addr", mem_addr, addr);
            if (we) chk("mem_wdata", mem_wdata, wd);
            chk("ext_grant", ext_grant, grant);
            chk("acc_cpu_enable", cpu_enable, 0);
            chk("acc_ext_done", ext_done, 0);
            if (mem_ready) begin
                rd = mem_rdata;
                ok = 1'b1;
                fin = 1;
            end else begin
                waits++;
                if (waits >= TO) fin = 1;
            end
        end
        if (!ok) begin
            m_err = 1'b1;
            @(negedge clk);
            chk("err_bus_error", bus_error, 1);
            chk("err_mem_req", mem_req, 0);
        end
    endtask

    // one visit of the arbitration point and everything it starts
    task automatic model_step();
        logic [15:0] rd, a, wd;
        logic        ok, we;
        bit          do_ext, do_cpu;
        last_len = 1;
        last_kind = 0;
        @(negedge clk);
        chk("arb_instr", instr, e_instr);
        chk("arb_cpu_rdata", cpu_rdata, e_cpu_rd);
        chk("arb_ext_rdata", ext_rdata, e_ext_rd);
        chk("arb_mem_req", mem_req, 0);
        chk("arb_cpu_enable", cpu_enable, 0);
        chk("arb_ext_grant", ext_grant, 0);
        chk("arb_ext_done", ext_done, m_done_pend);
        chk("arb_bus_error", bus_error, 0);
        m_done_pend = 1'b0;
        do_ext = 0;
        do_cpu = 0;
        if (ext_req && !m_last) do_ext = 1;
        else if (!halt) do_cpu = 1;
        else if (ext_req) do_ext = 1;
        if (do_ext) begin
            last_kind = 2;
            n_ext++;
            we = ext_we;
            a  = ext_addr;
            wd = ext_wdata;
            access(1'b1, we, a, wd, rd, ok);
            if (ok) begin
                if (!we) e_ext_rd = rd;
                m_last = 1'b1;
                m_done_pend = 1'b1;
            end
        end else if (do_cpu) begin
            last_kind = 1;
            n_fetch++;
            m_last = 1'b0;
            m_fetch_addr = pc_addr;
            access(1'b0, 1'b0, m_fetch_addr, 16'h0000, rd, ok);
            if (ok) begin
                e_instr = rd;
                idle_cycle(1'b0);
                if (cpu_mem_r || cpu_mem_w) begin
                    we = cpu_mem_w;
                    access(1'b0, we, cpu_addr, cpu_wdata, rd, ok);
                    if (ok && !we) e_cpu_rd = rd;
                end
                if (ok) idle_cycle(1'b1);
            end
        end
    endtask

    task automatic model_run(input int n);
        for (int k = 0; k < n && !m_err; k++) model_step();
    endtask

    task automatic model_clear();
        m_last = 1'b0;
        m_done_pend = 1'b0;
        m_err = 1'b0;
        e_instr = '0;
        e_cpu_rd = '0;
        e_ext_rd = '0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 reset = 1'b1;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        model_clear();
    endtask

    initial begin : main
        int kinds [8];
        int f0, e0, reqc, bad;
        bit found;
        model_clear();
        m_fetch_addr = '0;
        dmem[16'h0000] = 16'h1231;
        dmem[16'h0001] = 16'h8040;
        dmem[16'h0040] = 16'hBEEF;
        dmem[16'h0002] = 16'hC010;
        dmem[16'h0100] = 16'h5555;
        dmem[16'h0200] = 16'h8040;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_cpu_enable", cpu_enable, 0);
        chk("rst_ext_grant", ext_grant, 0);
        chk("rst_ext_done", ext_done, 0);
        chk("rst_bus_error", bus_error, 0);
        chk("rst_instr", instr, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_ext_rdata", ext_rdata, 0);
        #2 reset = 1'b0;

        // ALU instruction, zero-wait memory
        model_run(1);
        chk("alu_len", last_len, 4);
        chk("alu_instr", instr, 16'h1231);
        // load with two wait cycles
        model_run(1);
        chk("load_len", last_len, 7);
        chk("load_rdata", cpu_rdata, 16'hBEEF);
        // store wins over load
        model_run(1);
        chk("store_len", last_len, 5);
        chk("store_rdata_kept", cpu_rdata, 16'hBEEF);

        // requester held high: strict alternation
        ext_mode = 2;
        for (int i = 0; i < 8; i++) begin
            model_step();
            kinds[i] = last_kind;
        end
        for (int i = 0; i < 8; i++) chk("alternate", kinds[i], (i % 2 == 0) ? 2 : 1);
        chk("ext_len", (kinds[0] == 2) ? 0 : 1, 0);
        chk("ext_rdata_5555", ext_rdata, 16'h5555);

        // random traffic
        ext_mode = 1;
        halt_sel = 2;
        pc_rand = 1;
        rf_rand = 1;
        maxw = 3;
        model_run(400);

        // halted: only the requester is served
        halt_sel = 1;
        f0 = n_fetch;
        e0 = n_ext;
        model_run(30);
        chk("halt_no_fetch", n_fetch - f0, 0);
        chk("halt_ext_served", ((n_ext - e0) > 0) ? 1 : 0, 1);

        // reset in the middle of a data access
        ext_mode = 0;
        halt_sel = 0;
        pc_rand = 0;
        rf_rand = 0;
        maxw = 0;
        slow_n = 8;
        pc_base = 16'h0200;
        do_reset();
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 16'h0040) found = 1;
        end
        chk("reach_data", found, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_mem_req", mem_req, 0);
        chk("async_instr", instr, 0);
        pc_base = 16'h0300;
        @(posedge clk);
        #3 reset = 1'b0;
        model_clear();
        model_run(1);
        chk("post_rst_kind", last_kind, 1);
        chk("post_rst_pc", m_fetch_addr, 16'h0300);

        // ready never comes
        stuck = 1;
        do_reset();
        found = 0;
        reqc = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus_error) found = 1;
            else if (mem_req) reqc++;
        end
        chk("timeout_seen", found, 1);
        chk("timeout_cycles", reqc, 15);
        ext_mode = 2;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mem_req || cpu_enable || ext_grant || ext_done || !bus_error) bad++;
        end
        chk("error_quiet", bad, 0);
        stuck = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
